// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index width and pipeline controller FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_types_pkg;

  localparam int REG_W = 5;

  typedef logic [REG_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources of ID.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the controller decides whether the bubble is taken.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     memtoReg_EX,
  input  regbits_t rt_EX,
  input  regbits_t rs_ID,
  input  regbits_t rt_ID,
  output logic     load_use
);

  // Register zero is hardwired, so a load targeting it never creates a hazard.
  always_comb begin
    load_use = memtoReg_EX & (rt_EX != '0) & ((rt_EX == rs_ID) | (rt_EX == rt_ID));
  end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline latch enable/flush sequencing, fetch/data stall arbitration, halt drain.
// Latency: enables, flushes and gated requests are combinational; halt is registered.
// Backpressure: whole pipeline freezes until both ihit and the MEM data access are done.
module pipeline_controller
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_MEM,
  input  logic             dWEN_MEM,
  input  logic             memtoReg_EX,
  input  regbits_t         rt_EX,
  input  regbits_t         rs_ID,
  input  regbits_t         rt_ID,
  input  logic             redirect_MEM,
  input  logic             halt_MEM,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  pipe_state_t state, next_state;
  logic        dmem_done;
  logic        advance;
  logic        mem_op;
  logic        load_use;

  hazard_detect u_hazard (
    .memtoReg_EX (memtoReg_EX),
    .rt_EX       (rt_EX),
    .rs_ID       (rs_ID),
    .rt_ID       (rt_ID),
    .load_use    (load_use)
  );

  // Next state, advance decision and all combinational latch controls.
  always_comb begin
    next_state  = state;
    advance     = 1'b0;
    mem_op      = dREN_MEM | dWEN_MEM;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    // A finished access is held off the cache until the pipeline moves on.
    dmemREN     = dREN_MEM & ~dmem_done;
    dmemWEN     = dWEN_MEM & ~dmem_done;

    case (state)
      RUN: begin
        advance = ihit & (~mem_op | dhit | dmem_done);
        if (advance) begin
          if (halt_MEM) begin
            // Let the halt retire into WB and squash everything younger.
            memwb_en    = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            next_state  = DRAIN;
          end else if (redirect_MEM) begin
            // Wrong-path squash; also hides any load-use in ID since ID is discarded.
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
          end else if (load_use) begin
            // Hold PC and IF/ID, push a bubble into EX.
            idex_en     = 1'b1;
            idex_flush  = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
          end else begin
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            idex_en     = 1'b1;
            exmem_en    = 1'b1;
            memwb_en    = 1'b1;
          end
        end
      end
      DRAIN: begin
        memwb_en   = 1'b1;
        next_state = HALTED;
      end
      HALTED: begin
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
      end
      default: begin
        next_state = RUN;
      end
    endcase

    // Everything the latches see is forced low while reset is held.
    if (!nRST) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      dmemREN     = 1'b0;
      dmemWEN     = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= next_state;
  end

  // Remember a data access that finished while still waiting on fetch.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)        dmem_done <= 1'b0;
    else if (advance) dmem_done <= 1'b0;
    else if (dhit)    dmem_done <= 1'b1;
  end

  // Sticky halt flag, raised as DRAIN hands over to HALTED.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)               halt <= 1'b0;
    else if (state == DRAIN) halt <= 1'b1;
  end

  // Saturating count of frozen cycles while running.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      stall_cnt <= '0;
    else if ((state == RUN) && !advance && (stall_cnt != CNT_MAX))
      stall_cnt <= stall_cnt + CNT_ONE;
  end

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: vector table plus multi-cycle sequences.
// Latency: combinational outputs sampled 1 time unit after the falling edge.
// Backpressure: n/a.
module tb_pipeline_controller;

  logic       CLK, nRST;
  logic       ihit, dhit, dREN_MEM, dWEN_MEM, memtoReg_EX, redirect_MEM, halt_MEM;
  logic [4:0] rt_EX, rs_ID, rt_ID;

  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic dmemREN, dmemWEN, halt;
  logic [15:0] stall_cnt;

  logic pc_en4, ifid_en4, idex_en4, exmem_en4, memwb_en4;
  logic ifid_flush4, idex_flush4, exmem_flush4, memwb_flush4;
  logic dmemREN4, dmemWEN4, halt4;
  logic [3:0] stall_cnt4;

  int n_cmp = 0;
  int n_err = 0;

  pipeline_controller #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dREN_MEM(dREN_MEM), .dWEN_MEM(dWEN_MEM), .memtoReg_EX(memtoReg_EX),
    .rt_EX(rt_EX), .rs_ID(rs_ID), .rt_ID(rt_ID),
    .redirect_MEM(redirect_MEM), .halt_MEM(halt_MEM),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .halt(halt), .stall_cnt(stall_cnt)
  );

  pipeline_controller #(.CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .dREN_MEM(dREN_MEM), .dWEN_MEM(dWEN_MEM), .memtoReg_EX(memtoReg_EX),
    .rt_EX(rt_EX), .rs_ID(rs_ID), .rt_ID(rt_ID),
    .redirect_MEM(redirect_MEM), .halt_MEM(halt_MEM),
    .pc_en(pc_en4), .ifid_en(ifid_en4), .idex_en(idex_en4), .exmem_en(exmem_en4), .memwb_en(memwb_en4),
    .ifid_flush(ifid_flush4), .idex_flush(idex_flush4), .exmem_flush(exmem_flush4), .memwb_flush(memwb_flush4),
    .dmemREN(dmemREN4), .dmemWEN(dmemWEN4), .halt(halt4), .stall_cnt(stall_cnt4)
  );

  // {pc, ifid, idex, exmem, memwb enables | ifid, idex, exmem, memwb flushes | dREN, dWEN}
  logic [10:0] outs;
  assign outs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                 ifid_flush, idex_flush, exmem_flush, memwb_flush, dmemREN, dmemWEN};

  localparam logic [10:0] O_IDLE  = 11'b00000_0000_00;
  localparam logic [10:0] O_RUN   = 11'b11111_0000_00;
  localparam logic [10:0] O_LU    = 11'b00111_0100_00;
  localparam logic [10:0] O_RDIR  = 11'b11111_1110_00;
  localparam logic [10:0] O_HALT  = 11'b01111_1110_00;
  localparam logic [10:0] O_DRAIN = 11'b00001_0000_00;

  typedef struct {
    string       name;
    logic        ihit, dhit, dren, dwen, mtr, redir;
    logic [4:0]  rt_ex, rs_id, rt_id;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; dREN_MEM = 1'b0; dWEN_MEM = 1'b0;
    memtoReg_EX = 1'b0; redirect_MEM = 1'b0; halt_MEM = 1'b0;
    rt_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0;
  endtask

  function automatic vec_t mk(input string nm, input logic ih, input logic dh, input logic dr,
                              input logic dw, input logic mt, input logic [4:0] rte,
                              input logic [4:0] rsi, input logic [4:0] rti,
                              input logic rd, input logic [10:0] e);
    vec_t v;
    v.name = nm; v.ihit = ih; v.dhit = dh; v.dren = dr; v.dwen = dw; v.mtr = mt;
    v.rt_ex = rte; v.rs_id = rsi; v.rt_id = rti; v.redir = rd; v.exp = e;
    return v;
  endfunction

  initial begin
    //               name               ihit dhit dren dwen mtr rtEX rsID rtID redir expected
    vecs[0]  = mk("v_plain_run",        1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_RUN);
    vecs[1]  = mk("v_no_ihit",          0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, O_IDLE);
    vecs[2]  = mk("v_load_wait_dhit",   1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 11'b00000_0000_10);
    vecs[3]  = mk("v_load_same_cycle",  1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 11'b11111_0000_10);
    vecs[4]  = mk("v_store_same_cycle", 1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 11'b11111_0000_01);
    vecs[5]  = mk("v_loaduse_rs",       1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, O_LU);
    vecs[6]  = mk("v_loaduse_rt",       1, 0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0, O_LU);
    vecs[7]  = mk("v_loaduse_r0",       1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 0, O_RUN);
    vecs[8]  = mk("v_not_load",         1, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5, 0, O_RUN);
    vecs[9]  = mk("v_redirect",         1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 1, O_RDIR);
    vecs[10] = mk("v_redirect_lu",      1, 0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 1, O_RDIR);
    vecs[11] = mk("v_loaduse_noihit",   0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, O_IDLE);
    vecs[12] = mk("v_loaduse_memwait",  1, 0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 11'b00000_0000_10);

    // Reset held with fetch active: everything low.
    idle_inputs();
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("reset_outs", {20'd0, outs, halt}, 32'd0);
    check("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("post_reset_run", {21'd0, outs}, {21'd0, O_RUN});
    check("post_reset_cnt", {16'd0, stall_cnt}, 32'd0);

    // Vector table; four of these entries freeze the pipe.
    for (int i = 0; i < 13; i++) begin
      @(negedge CLK);
      ihit = vecs[i].ihit; dhit = vecs[i].dhit; dREN_MEM = vecs[i].dren;
      dWEN_MEM = vecs[i].dwen; memtoReg_EX = vecs[i].mtr; rt_EX = vecs[i].rt_ex;
      rs_ID = vecs[i].rs_id; rt_ID = vecs[i].rt_id; redirect_MEM = vecs[i].redir;
      #1;
      check(vecs[i].name, {21'd0, outs}, {21'd0, vecs[i].exp});
    end
    @(negedge CLK);
    idle_inputs();
    #1;
    check("table_stall_cnt", {16'd0, stall_cnt}, 32'd4);

    // Data completes before fetch: request issued once, then held off.
    @(negedge CLK);
    ihit = 1'b0; dREN_MEM = 1'b1; dhit = 1'b1;
    #1;
    check("dfirst_req_issued", {21'd0, outs}, {21'd0, 11'b00000_0000_10});
    @(negedge CLK);
    dhit = 1'b0;
    #1;
    check("dfirst_req_dropped", {21'd0, outs}, {21'd0, O_IDLE});
    @(negedge CLK);
    ihit = 1'b1;
    #1;
    check("dfirst_advance", {21'd0, outs}, {21'd0, O_RUN});
    @(negedge CLK);
    #1;
    check("dfirst_next_op_issued", {21'd0, outs}, {21'd0, 11'b00000_0000_10});
    check("dfirst_stall_cnt", {16'd0, stall_cnt}, 32'd6);

    // Asynchronous reset in the middle of a stall.
    #2;
    nRST = 1'b0;
    #1;
    check("mid_stall_reset_cnt", {16'd0, stall_cnt}, 32'd0);
    check("mid_stall_reset_outs", {21'd0, outs}, 32'd0);
    @(negedge CLK);
    idle_inputs();
    nRST = 1'b1;

    // Halt together with redirect: halt wins, then drain, then sticky halt.
    @(negedge CLK);
    halt_MEM = 1'b1; redirect_MEM = 1'b1;
    #1;
    check("halt_vs_redirect", {20'd0, outs, halt}, {20'd0, O_HALT, 1'b0});
    @(negedge CLK);
    halt_MEM = 1'b0; redirect_MEM = 1'b0;
    #1;
    check("drain_cycle", {20'd0, outs, halt}, {20'd0, O_DRAIN, 1'b0});
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      ihit = i[0]; dREN_MEM = 1'b1; dWEN_MEM = i[1];
      #1;
      check($sformatf("halted_c%0d", i), {20'd0, outs, halt}, {20'd0, O_IDLE, 1'b1});
    end
    check("halted_no_count", {16'd0, stall_cnt}, 32'd0);

    // Reset pulled while draining returns to RUN with halt clear.
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    idle_inputs();
    nRST = 1'b1;
    @(negedge CLK);
    halt_MEM = 1'b1;
    #1;
    check("halt_alone", {21'd0, outs}, {21'd0, O_HALT});
    @(negedge CLK);
    halt_MEM = 1'b0;
    #1;
    check("drain_again", {21'd0, outs}, {21'd0, O_DRAIN});
    #2;
    nRST = 1'b0;
    #1;
    check("mid_drain_reset", {20'd0, outs, halt}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    check("after_drain_reset_run", {20'd0, outs, halt}, {20'd0, O_RUN, 1'b0});

    // Saturation: narrow counter sticks at all-ones, wide one keeps counting.
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    idle_inputs();
    ihit = 1'b0;
    nRST = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge CLK);
      #1;
      if (i == 15) check("sat4_reach", {28'd0, stall_cnt4}, 32'd15);
      if (i == 16) check("sat4_hold_16", {28'd0, stall_cnt4}, 32'd15);
    end
    check("sat4_hold_20", {28'd0, stall_cnt4}, 32'd15);
    check("cnt16_20", {16'd0, stall_cnt}, 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
